// File: rtl/mem8_arb.sv
// mem8_arb: two-port round-robin arbiter and access sequencer for the 8-bit spram8_128k memory.
// Define MEM8_ARB_WORD_EN to build 16-bit big-endian word accesses (A1 beat, hi register).
module mem8_arb #(
  parameter int ASZ = 17,
  parameter int DSZ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               we0,
  input  logic               wide0,
  input  logic [ASZ-1:0]     a0,
  input  logic [2*DSZ-1:0]   d0,
  input  logic               req1,
  input  logic               we1,
  input  logic               wide1,
  input  logic [ASZ-1:0]     a1,
  input  logic [2*DSZ-1:0]   d1,
  output logic               ack0,
  output logic               ack1,
  output logic               gnt0,
  output logic               gnt1,
  output logic [2*DSZ-1:0]   q,
  output logic [ASZ-1:0]     mem_a,
  output logic [DSZ-1:0]     mem_vi,
  output logic               mem_we,
  input  logic [DSZ-1:0]     mem_vo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_A0   = 2'd1,
    ST_A1   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  state_t         state_r;
  logic           port_r;
  logic           last_r;
  logic           we_r;
  logic [ASZ-1:0] addr_r;

  logic           any_s;
  logic           win_s;
  logic           sel_we_s;
  logic [ASZ-1:0] sel_a_s;
  logic [DSZ-1:0] sel_lo_s;
  logic [DSZ-1:0] sel_vi_s;
  logic           sel_done_s;

`ifdef MEM8_ARB_WORD_EN
  logic           wide_r;
  logic [DSZ-1:0] data_r;
  logic [DSZ-1:0] hi_r;
  logic           sel_wide_s;
  logic [DSZ-1:0] sel_hi_s;
`else
  logic           unused_s;
  assign unused_s = ^{wide0, wide1, d0[2*DSZ-1:DSZ], d1[2*DSZ-1:DSZ]};
`endif

  // Round-robin winner and its request fields, used only in an IDLE cycle
  always_comb begin
    any_s = req0 | req1;
    if (req0 && req1) begin
      win_s = ~last_r;
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    if (win_s) begin
      sel_we_s = we1;
      sel_a_s  = a1;
      sel_lo_s = d1[DSZ-1:0];
    end else begin
      sel_we_s = we0;
      sel_a_s  = a0;
      sel_lo_s = d0[DSZ-1:0];
    end
`ifdef MEM8_ARB_WORD_EN
    sel_wide_s = win_s ? wide1 : wide0;
    sel_hi_s   = win_s ? d1[2*DSZ-1:DSZ] : d0[2*DSZ-1:DSZ];
    sel_vi_s   = sel_wide_s ? sel_hi_s : sel_lo_s;
    sel_done_s = sel_we_s & ~sel_wide_s;
`else
    sel_vi_s   = sel_lo_s;
    sel_done_s = sel_we_s;
`endif
  end

  // Access sequencer; memory strobes and handshakes are all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      port_r  <= 1'b0;
      last_r  <= 1'b1;
      we_r    <= 1'b0;
      addr_r  <= {ASZ{1'b0}};
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      mem_we  <= 1'b0;
      mem_a   <= {ASZ{1'b0}};
      mem_vi  <= {DSZ{1'b0}};
`ifdef MEM8_ARB_WORD_EN
      wide_r  <= 1'b0;
      data_r  <= {DSZ{1'b0}};
      hi_r    <= {DSZ{1'b0}};
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            state_r <= ST_A0;
            port_r  <= win_s;
            we_r    <= sel_we_s;
            addr_r  <= sel_a_s;
            gnt0    <= ~win_s;
            gnt1    <= win_s;
            mem_a   <= sel_a_s;
            mem_vi  <= sel_vi_s;
            mem_we  <= sel_we_s;
            ack0    <= sel_done_s & ~win_s;
            ack1    <= sel_done_s & win_s;
`ifdef MEM8_ARB_WORD_EN
            wide_r  <= sel_wide_s;
            data_r  <= sel_lo_s;
`endif
          end else begin
            mem_we <= 1'b0;
          end
        end
        ST_A0: begin
`ifdef MEM8_ARB_WORD_EN
          if (wide_r) begin
            state_r <= ST_A1;
            mem_a   <= addr_r + {{(ASZ-1){1'b0}}, 1'b1};
            mem_vi  <= data_r;
            mem_we  <= we_r;
            ack0    <= we_r & ~port_r;
            ack1    <= we_r & port_r;
          end else
`endif
          if (we_r) begin
            state_r <= ST_IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            mem_we  <= 1'b0;
            last_r  <= port_r;
          end else begin
            state_r <= ST_RD;
            mem_we  <= 1'b0;
            ack0    <= ~port_r;
            ack1    <= port_r;
          end
        end
`ifdef MEM8_ARB_WORD_EN
        ST_A1: begin
          hi_r   <= mem_vo;
          mem_we <= 1'b0;
          if (we_r) begin
            state_r <= ST_IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            last_r  <= port_r;
          end else begin
            state_r <= ST_RD;
            ack0    <= ~port_r;
            ack1    <= port_r;
          end
        end
`endif
        ST_RD: begin
          state_r <= ST_IDLE;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          mem_we  <= 1'b0;
          last_r  <= port_r;
        end
        default: begin
          state_r <= ST_IDLE;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // Read data is only meaningful in RD, where mem_vo carries the last byte read
  always_comb begin
    if (state_r == ST_RD) begin
`ifdef MEM8_ARB_WORD_EN
      q = wide_r ? {hi_r, mem_vo} : {{DSZ{1'b0}}, mem_vo};
`else
      q = {{DSZ{1'b0}}, mem_vo};
`endif
    end else begin
      q = {(2*DSZ){1'b0}};
    end
  end

endmodule
